// File: rtl/pls_seg_gen_if.sv
// ----------------------------------------------------------------------------
// pls_seg_gen_if
// AXI-Stream bundle carrying the generated waveform samples.
//
// Signals:
//   m_tdata  : signed sample (DATA_SIZE bits)
//   m_tvalid : sample valid
//   m_tready : downstream ready
//   m_tlast  : last sample of a signal period
//
// Modports:
//   master : driven by the generator (pls_seg_gen)
//   slave  : driven by the consumer (drives m_tready)
// ----------------------------------------------------------------------------
interface pls_seg_gen_if #(
    parameter int DATA_SIZE = 32
);
    logic signed [DATA_SIZE-1:0] m_tdata;
    logic                        m_tvalid;
    logic                        m_tready;
    logic                        m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/pls_seg_gen.sv
// ----------------------------------------------------------------------------
// pls_seg_gen
// Piecewise-linear segment generator. A signal period is made of up to
// linenmb segments; each segment is fetched from an external descriptor
// store (start value, increment, point count) and streamed as a ramp on an
// AXI-Stream master. Periods repeat cfg_repeat times (0 = forever) and the
// configuration group is re-sampled at every period start.
//
// Optional feature:
//   PLS_SATURATE_EN : when defined, the ramp accumulator saturates at the
//                     signed limits instead of wrapping modulo 2^DATA_SIZE.
//
// Ports:
//   aclk, aresetn     : clock, synchronous active-low reset
//   start, stop       : one-cycle control pulses
//   group_select      : configuration group for the next period
//   cfg_linenmb       : per-group segment count, group g at [8g+7:8g]
//   cfg_repeat        : per-group period repetitions, group g at [CNT_W*g +: CNT_W]
//   cfg_rd_en/grp/seg : descriptor read request
//   cfg_linea/offset/points : descriptor data, valid 1 cycle after cfg_rd_en
//   m_axis            : AXI-Stream master (pls_seg_gen_if.master)
//   busy              : high while not idle
//   done              : one-cycle pulse when returning to idle
// ----------------------------------------------------------------------------
module pls_seg_gen #(
    parameter int DATA_SIZE = 32,
    parameter int SEG_MAX   = 16,
    parameter int CNT_W     = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        group_select,
    input  logic [15:0]                 cfg_linenmb,
    input  logic [2*CNT_W-1:0]          cfg_repeat,
    output logic                        cfg_rd_en,
    output logic                        cfg_rd_grp,
    output logic [7:0]                  cfg_rd_seg,
    input  logic signed [DATA_SIZE-1:0] cfg_linea,
    input  logic signed [DATA_SIZE-1:0] cfg_offset,
    input  logic [CNT_W-1:0]            cfg_points,
    pls_seg_gen_if.master               m_axis,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [8:0] SEG_LIM = 9'(SEG_MAX);

    // Ramp step: saturating or wrapping add of the segment increment.
    function automatic logic signed [DATA_SIZE-1:0] acc_add(
        input logic signed [DATA_SIZE-1:0] a,
        input logic signed [DATA_SIZE-1:0] b
    );
`ifdef PLS_SATURATE_EN
        logic signed [DATA_SIZE:0] s;
        s = {a[DATA_SIZE-1], a} + {b[DATA_SIZE-1], b};
        // Overflow when the extra sign bit disagrees with the result sign.
        if (s[DATA_SIZE] != s[DATA_SIZE-1])
            return s[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                : {1'b0, {(DATA_SIZE-1){1'b1}}};
        return s[DATA_SIZE-1:0];
`else
        return a + b;
`endif
    endfunction

    state_t                      state_q, state_d;
    logic                        grp_q, grp_d;
    logic [8:0]                  seg_q, seg_d;
    logic [CNT_W-1:0]            rep_q, rep_d;
    logic [CNT_W-1:0]            pcnt_q, pcnt_d;
    logic [CNT_W-1:0]            pts_q, pts_d;
    logic signed [DATA_SIZE-1:0] acc_q, acc_d;
    logic signed [DATA_SIZE-1:0] off_q, off_d;
    logic                        stop_q, stop_d;

    logic [7:0]       lin_cur, lin_new;
    logic [CNT_W-1:0] rep_cur;
    logic [8:0]       seg_nx;
    logic [CNT_W-1:0] rep_nx;
    logic             period_end;
    logic             last_rep;
    logic             last_pt;
    logic             run;

    // Segment-advance outcome, shared by FETCH (empty segment) and RUN.
    state_t     adv_state;
    logic [8:0] adv_seg;
    logic       adv_grp;
    logic [CNT_W-1:0] adv_rep;

    assign lin_cur    = grp_q ? cfg_linenmb[15:8] : cfg_linenmb[7:0];
    assign lin_new    = group_select ? cfg_linenmb[15:8] : cfg_linenmb[7:0];
    assign rep_cur    = grp_q ? cfg_repeat[2*CNT_W-1:CNT_W] : cfg_repeat[CNT_W-1:0];
    assign seg_nx     = seg_q + 9'd1;
    assign rep_nx     = rep_q + CNT_W'(1);
    assign period_end = (seg_nx >= {1'b0, lin_cur}) || (seg_nx >= SEG_LIM);
    assign last_rep   = (rep_cur != '0) && (rep_nx == rep_cur);
    assign last_pt    = (pcnt_q == pts_q - CNT_W'(1));
    assign run        = (state_q == S_RUN);

    always_comb begin
        adv_state = S_LOAD;
        adv_seg   = seg_nx;
        adv_grp   = grp_q;
        adv_rep   = rep_q;
        if (period_end) begin
            if (last_rep) begin
                adv_state = S_DRAIN;
                adv_seg   = seg_q;
            end else begin
                // Period wrap: new group sampled here and nowhere mid-period.
                adv_seg   = '0;
                adv_rep   = rep_nx;
                adv_grp   = group_select;
                adv_state = (lin_new == 8'd0) ? S_DRAIN : S_LOAD;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            grp_q   <= 1'b0;
            seg_q   <= '0;
            rep_q   <= '0;
            pcnt_q  <= '0;
            pts_q   <= '0;
            acc_q   <= '0;
            off_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            seg_q   <= seg_d;
            rep_q   <= rep_d;
            pcnt_q  <= pcnt_d;
            pts_q   <= pts_d;
            acc_q   <= acc_d;
            off_q   <= off_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        seg_d   = seg_q;
        rep_d   = rep_q;
        pcnt_d  = pcnt_q;
        pts_d   = pts_q;
        acc_d   = acc_q;
        off_d   = off_q;
        stop_d  = stop_q | stop;

        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (start && (lin_new != 8'd0)) begin
                    state_d = S_LOAD;
                    grp_d   = group_select;
                    seg_d   = '0;
                    rep_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = stop_q ? S_DRAIN : S_FETCH;
            end
            S_FETCH: begin
                if (stop_q) begin
                    state_d = S_DRAIN;
                end else begin
                    acc_d  = cfg_linea;
                    off_d  = cfg_offset;
                    pts_d  = cfg_points;
                    pcnt_d = '0;
                    if (cfg_points == '0) begin
                        state_d = adv_state;
                        seg_d   = adv_seg;
                        grp_d   = adv_grp;
                        rep_d   = adv_rep;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (m_axis.m_tready) begin
                    acc_d  = acc_add(acc_q, off_q);
                    pcnt_d = pcnt_q + CNT_W'(1);
                    if (stop_q) begin
                        state_d = S_DRAIN;
                    end else if (last_pt) begin
                        state_d = adv_state;
                        seg_d   = adv_seg;
                        grp_d   = adv_grp;
                        rep_d   = adv_rep;
                    end
                end
            end
            S_DRAIN: begin
                stop_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                stop_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DRAIN);
    assign cfg_rd_en       = (state_q == S_LOAD);
    assign cfg_rd_grp      = grp_q;
    assign cfg_rd_seg      = seg_q[7:0];
    assign m_axis.m_tvalid = run;
    assign m_axis.m_tdata  = run ? acc_q : '0;
    assign m_axis.m_tlast  = run && last_pt && period_end;

endmodule

// File: doc/pls_seg_gen.md
PLS_SEG_GEN -- requirements
Module: pls_seg_gen

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter SEG_MAX, default 16, maximum segments per signal period (2..256).
REQ-003 SHALL have parameter CNT_W, default 32, width of point and repetition counters.
REQ-004 SHALL have port aclk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  in  1  reset: reset aresetn, synchronous, active-low; clock aclk.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begin generation when idle.
REQ-007 SHALL have port stop  in  1  one-cycle pulse; graceful halt request.
REQ-008 SHALL have port group_select  in  1  config group used for the next signal period.
REQ-009 SHALL have port cfg_linenmb  in  2*8  per-group segment count; group g at bits [8g+7:8g].
REQ-010 SHALL have port cfg_repeat  in  2*CNT_W  per-group period repetitions; 0 = infinite.
REQ-011 SHALL have port cfg_rd_en  out  1  segment descriptor read strobe.
REQ-012 SHALL have port cfg_rd_grp  out  1  group of the read.
REQ-013 SHALL have port cfg_rd_seg  out  8  segment index of the read.
REQ-014 SHALL have ports cfg_linea, cfg_offset (in, DATA_SIZE) and cfg_points (in, CNT_W): start value, increment and point count, valid exactly 1 cycle after cfg_rd_en.
REQ-015 SHALL have ports m_tdata (out, DATA_SIZE), m_tvalid (out, 1), m_tready (in, 1), m_tlast (out, 1) forming an AXI-Stream master.
REQ-016 SHALL have ports busy (out, 1), high while not IDLE, and done (out, 1), a one-cycle pulse on return to IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, FETCH, RUN, DRAIN.
REQ-018 SHALL transition IDLE->LOAD on start when the selected group's linenmb!=0; when linenmb==0, SHALL ignore start.
REQ-019 SHALL, in LOAD, assert cfg_rd_en for one cycle with the current group/segment; LOAD->FETCH.
REQ-020 SHALL, in FETCH, capture linea/offset/points, set accumulator=linea and point counter=0; FETCH->RUN, or ->LOAD for the next segment when points==0.
REQ-021 SHALL, in RUN, present the accumulator on m_tdata with m_tvalid=1; on each m_tvalid&m_tready, SHALL set accumulator+=offset and point counter+=1.
REQ-022 SHALL sustain one sample per cycle within a segment while m_tready=1; each segment change SHALL cost exactly 2 bubble cycles (LOAD, FETCH).
REQ-023 SHALL hold m_tdata, m_tvalid and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL assert m_tlast only on the last point of the last segment of a period.
REQ-025 SHALL, after the last point of a segment, advance the segment and go to LOAD; after the last segment, SHALL increment the repetition counter and reset the segment to 0.
REQ-026 SHALL latch group_select only at period start (IDLE->LOAD and each period wrap); mid-period changes SHALL have no effect.
REQ-027 SHALL go to DRAIN after the last handshake of the final repetition when repeat!=0; DRAIN SHALL last one cycle, pulse done and go to IDLE.
REQ-028 SHALL register stop as a pending flag; in LOAD/FETCH SHALL go directly to DRAIN; in RUN SHALL go to DRAIN after the next handshake; in IDLE SHALL ignore it.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL treat a segment index >= SEG_MAX as end of period.

Reset
REQ-031 SHALL, on aresetn=0 at a rising edge, force state IDLE and m_tvalid, m_tlast, m_tdata, cfg_rd_en, busy, done, all counters and the accumulator to 0 and the stop flag cleared, from any state including mid-transfer.

Configuration
REQ-032 SHALL, with macro PLS_SATURATE_EN defined, clamp the accumulator add to the signed limits 2^(DATA_SIZE-1)-1 / -2^(DATA_SIZE-1).
REQ-033 SHALL, with PLS_SATURATE_EN undefined, wrap the accumulator add modulo 2^DATA_SIZE.

Verification
REQ-034 SHALL cover: grp0 linenmb=2, repeat=1, seg0 (linea=10, offset=5, points=3), seg1 (linea=100, offset=-1, points=2), m_tready=1 -> tdata 10,15,20,100,99; tlast on 99; done 1 cycle later.
REQ-035 SHALL cover: same config with m_tready toggling 1/0 -> identical sequence; tdata/tvalid stable during every stall.
REQ-036 SHALL cover: repeat=0 with stop pulsed mid-segment 1 -> exactly one further beat, then DRAIN, done, IDLE.
REQ-037 SHALL cover: linea=0x7FFFFFF0, offset=0x20, points=2 -> beat 2 is 0x7FFFFFFF with PLS_SATURATE_EN defined, 0x80000010 without it.
REQ-038 SHALL cover: group_select flipped mid-period with repeat=2 -> period 1 from the old group, period 2 from the new group; linenmb=0 start -> busy stays 0.
REQ-039 SHALL cover: aresetn low during RUN with tvalid=1 -> next cycle all outputs 0, state IDLE.
